mem_ext_loader: RTL and testbench

//  Host-side initiator for the cpu external memory ports. Streams a program into instruction memory,

---
 rtl/mem_loader_pkg.sv | 28 ++
 rtl/loader_down_counter.sv | 39 +++
 rtl/mem_ext_loader.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_mem_ext_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared states, byte-offset constants and stage sequencing helper for mem_ext_loader
package mem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      VERIFY   = 3'd2,
      RUN      = 3'd3,
      DUMP_RD  = 3'd4,
      DUMP_OUT = 3'd5
   } loader_state_e;

   // word index -> byte address shift for the 32-bit imem and 64-bit dmem ports
   localparam int IMEM_BYTE_SH = 2;
   localparam int DMEM_BYTE_SH = 3;

   // First non-empty stage that follows program loading (IDLE when nothing is left to do)
   function automatic loader_state_e stage_after_load(input logic run_nz, input logic dump_nz);
      if (run_nz) begin
         return RUN;
      end else if (dump_nz) begin
         return DUMP_RD;
      end else begin
         return IDLE;
      end
   endfunction

endpackage

// File: rtl/loader_down_counter.sv
// rtl/loader_down_counter.sv - loadable down counter with zero and last-count flags
module loader_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         dec_i,
   output logic         zero_o,
   output logic         last_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Load has priority; decrement saturates at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);
   assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/mem_ext_loader.sv
// rtl/mem_ext_loader.sv - host-side imem load / run / dmem dump sequencer; MEM_LOADER_VERIFY_EN adds imem readback check
module mem_ext_loader
   import mem_loader_pkg::*;
#(
   parameter int IMEM_ADDR_W = 9,
   parameter int DMEM_ADDR_W = 10,
   parameter int CYC_W       = 32
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   start,
   input  logic [IMEM_ADDR_W:0]   imem_words,
   input  logic [CYC_W-1:0]       run_cycles,
   input  logic [DMEM_ADDR_W-1:0] dmem_base,
   input  logic [DMEM_ADDR_W:0]   dmem_words,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [31:0]            s_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [63:0]            m_data,
   output logic [63:0]            addr_ext,
   output logic                   wen_ext,
   output logic                   ren_ext,
   output logic [31:0]            wdata_ext,
   input  logic [31:0]            rdata_ext,
   output logic [63:0]            addr_ext_2,
   output logic                   wen_ext_2,
   output logic                   ren_ext_2,
   output logic [63:0]            wdata_ext_2,
   input  logic [63:0]            rdata_ext_2,
   output logic                   cpu_enable,
   output logic                   busy,
`ifdef MEM_LOADER_VERIFY_EN
   output logic                   verify_err,
`endif
   output logic                   done
);

   loader_state_e          state_q, state_d;
   logic [IMEM_ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [DMEM_ADDR_W-1:0] k_q, k_d;
   logic [DMEM_ADDR_W-1:0] dmem_base_q, dmem_base_d;
   logic [63:0]            m_data_q, m_data_d;
   logic                   cap_q, cap_d;
   logic                   done_q, done_d;

   logic                   cnt_load;
   logic                   ld_dec, run_dec, dmp_dec;
   logic                   ld_last, run_last, dmp_last;
   logic                   run_zero, dmp_zero;
   logic                   unused_ld_zero;
   logic [IMEM_ADDR_W-1:0] iaddr_idx;
   logic [DMEM_ADDR_W-1:0] daddr_idx;

`ifdef MEM_LOADER_VERIFY_EN
   logic [IMEM_ADDR_W:0]   vidx_q, vidx_d;
   logic [IMEM_ADDR_W:0]   imem_words_q, imem_words_d;
   logic [31:0]            xor_ld_q, xor_ld_d;
   logic [31:0]            xor_rd_q, xor_rd_d;
   logic                   rd_pend_q, rd_pend_d;
   logic                   verify_err_q, verify_err_d;
`else
   logic                   unused_rdata_ext;
   assign unused_rdata_ext = ^rdata_ext;
`endif

   loader_down_counter #(.W(IMEM_ADDR_W + 1)) u_ld_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .load_i (cnt_load),
      .val_i  (imem_words),
      .dec_i  (ld_dec),
      .zero_o (unused_ld_zero),
      .last_o (ld_last)
   );

   loader_down_counter #(.W(CYC_W)) u_run_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .load_i (cnt_load),
      .val_i  (run_cycles),
      .dec_i  (run_dec),
      .zero_o (run_zero),
      .last_o (run_last)
   );

   loader_down_counter #(.W(DMEM_ADDR_W + 1)) u_dmp_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .load_i (cnt_load),
      .val_i  (dmem_words),
      .dec_i  (dmp_dec),
      .zero_o (dmp_zero),
      .last_o (dmp_last)
   );

   // Next-state, stage counters and port strobes; empty stages are skipped in the deciding cycle
   always_comb begin
      state_d     = state_q;
      word_idx_d  = word_idx_q;
      k_d         = k_q;
      dmem_base_d = dmem_base_q;
      m_data_d    = m_data_q;
      cap_d       = 1'b0;
      done_d      = 1'b0;
      cnt_load    = 1'b0;
      ld_dec      = 1'b0;
      run_dec     = 1'b0;
      dmp_dec     = 1'b0;
      s_ready     = 1'b0;
      wen_ext     = 1'b0;
      ren_ext     = 1'b0;
      wdata_ext   = '0;
      iaddr_idx   = word_idx_q;
      cpu_enable  = 1'b0;
      ren_ext_2   = 1'b0;
      m_valid     = 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
      vidx_d       = vidx_q;
      imem_words_d = imem_words_q;
      xor_ld_d     = xor_ld_q;
      xor_rd_d     = xor_rd_q;
      rd_pend_d    = 1'b0;
      verify_err_d = verify_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_load    = 1'b1;
               word_idx_d  = '0;
               k_d         = '0;
               dmem_base_d = dmem_base;
`ifdef MEM_LOADER_VERIFY_EN
               vidx_d       = '0;
               imem_words_d = imem_words;
               xor_ld_d     = '0;
               xor_rd_d     = '0;
               verify_err_d = 1'b0;
`endif
               if (imem_words != '0) begin
                  state_d = LOAD;
               end else begin
                  state_d = stage_after_load(run_cycles != '0, dmem_words != '0);
               end
               done_d = (state_d == IDLE);
            end
         end
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               wen_ext    = 1'b1;
               wdata_ext  = s_data;
               ld_dec     = 1'b1;
               word_idx_d = word_idx_q + IMEM_ADDR_W'(1);
`ifdef MEM_LOADER_VERIFY_EN
               xor_ld_d   = xor_ld_q ^ s_data;
               if (ld_last) begin
                  state_d = VERIFY;
               end
`else
               if (ld_last) begin
                  state_d = stage_after_load(!run_zero, !dmp_zero);
                  done_d  = (state_d == IDLE);
               end
`endif
            end
         end
`ifdef MEM_LOADER_VERIFY_EN
         VERIFY: begin
            // one read per cycle; each word lands a cycle later and is folded into the readback sum
            if (rd_pend_q) begin
               xor_rd_d = xor_rd_q ^ rdata_ext;
            end
            if (vidx_q != imem_words_q) begin
               ren_ext   = 1'b1;
               iaddr_idx = vidx_q[IMEM_ADDR_W-1:0];
               vidx_d    = vidx_q + (IMEM_ADDR_W + 1)'(1);
               rd_pend_d = 1'b1;
            end else if (!rd_pend_q) begin
               if (xor_rd_q != xor_ld_q) begin
                  verify_err_d = 1'b1;
               end
               state_d = stage_after_load(!run_zero, !dmp_zero);
               done_d  = (state_d == IDLE);
            end
         end
`endif
         RUN: begin
            cpu_enable = 1'b1;
            run_dec    = 1'b1;
            if (run_last) begin
               if (dmp_zero) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DUMP_RD;
               end
            end
         end
         DUMP_RD: begin
            ren_ext_2 = 1'b1;
            cap_d     = 1'b1;
            state_d   = DUMP_OUT;
         end
         DUMP_OUT: begin
            m_valid = 1'b1;
            if (cap_q) begin
               m_data_d = rdata_ext_2;
            end
            if (m_ready) begin
               k_d     = k_q + DMEM_ADDR_W'(1);
               dmp_dec = 1'b1;
               if (dmp_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DUMP_RD;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= IDLE;
         word_idx_q  <= '0;
         k_q         <= '0;
         dmem_base_q <= '0;
         m_data_q    <= '0;
         cap_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_idx_q  <= word_idx_d;
         k_q         <= k_d;
         dmem_base_q <= dmem_base_d;
         m_data_q    <= m_data_d;
         cap_q       <= cap_d;
         done_q      <= done_d;
      end
   end

`ifdef MEM_LOADER_VERIFY_EN
   // Readback check registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         vidx_q       <= '0;
         imem_words_q <= '0;
         xor_ld_q     <= '0;
         xor_rd_q     <= '0;
         rd_pend_q    <= 1'b0;
         verify_err_q <= 1'b0;
      end else begin
         vidx_q       <= vidx_d;
         imem_words_q <= imem_words_d;
         xor_ld_q     <= xor_ld_d;
         xor_rd_q     <= xor_rd_d;
         rd_pend_q    <= rd_pend_d;
         verify_err_q <= verify_err_d;
      end
   end

   assign verify_err = verify_err_q;
`endif

   // dump index wraps modulo the dmem size
   assign daddr_idx = dmem_base_q + k_q;

   // addresses are only driven while a strobe is active so idle ports stay all-zero
   assign addr_ext   = (wen_ext || ren_ext)
                     ? {{(64 - IMEM_ADDR_W - IMEM_BYTE_SH){1'b0}}, iaddr_idx, {IMEM_BYTE_SH{1'b0}}}
                     : '0;
   assign addr_ext_2 = ren_ext_2
                     ? {{(64 - DMEM_ADDR_W - DMEM_BYTE_SH){1'b0}}, daddr_idx, {DMEM_BYTE_SH{1'b0}}}
                     : '0;

   // read data bypasses the register in the first DUMP_OUT cycle, then is held from m_data_q
   assign m_data      = cap_q ? rdata_ext_2 : m_data_q;
   assign wen_ext_2   = 1'b0;
   assign wdata_ext_2 = '0;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;

endmodule

// File: tb/tb_mem_ext_loader.sv
// tb/tb_mem_ext_loader.sv - directed self-checking bench for mem_ext_loader
module tb_mem_ext_loader;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        start;
   logic [9:0]  imem_words;
   logic [31:0] run_cycles;
   logic [9:0]  dmem_base;
   logic [10:0] dmem_words;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [63:0] m_data;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [31:0] rdata_ext = '0;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic [63:0] rdata_ext_2 = '0;
   logic        cpu_enable;
   logic        busy;
   logic        done;
`ifdef MEM_LOADER_VERIFY_EN
   logic        verify_err;
`endif

   mem_ext_loader dut (
      .clk         (clk),
      .arst_n      (arst_n),
      .start       (start),
      .imem_words  (imem_words),
      .run_cycles  (run_cycles),
      .dmem_base   (dmem_base),
      .dmem_words  (dmem_words),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .addr_ext    (addr_ext),
      .wen_ext     (wen_ext),
      .ren_ext     (ren_ext),
      .wdata_ext   (wdata_ext),
      .rdata_ext   (rdata_ext),
      .addr_ext_2  (addr_ext_2),
      .wen_ext_2   (wen_ext_2),
      .ren_ext_2   (ren_ext_2),
      .wdata_ext_2 (wdata_ext_2),
      .rdata_ext_2 (rdata_ext_2),
      .cpu_enable  (cpu_enable),
      .busy        (busy),
`ifdef MEM_LOADER_VERIFY_EN
      .verify_err  (verify_err),
`endif
      .done        (done)
   );

   always #5 clk = ~clk;

   // memory models: synchronous read, one cycle latency
   logic [31:0] imem [0:511];
   logic [63:0] dmem [0:1023];
   logic        corrupt_w2 = 1'b0;

   always @(posedge clk) begin
      if (wen_ext) imem[addr_ext[10:2]] <= wdata_ext;
      if (ren_ext) rdata_ext <= imem[addr_ext[10:2]] ^
                                ((corrupt_w2 && addr_ext[10:2] == 9'd2) ? 32'h0000_00FF : 32'h0);
      if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
   end

   // activity monitor, sampled on the falling edge
   logic [63:0] wen_addr [$];
   logic [31:0] wen_data [$];
   logic [63:0] rd2_addr [$];
   logic [63:0] mout [$];
   int          en_n = 0, en_rise = 0, en_bad = 0, busy_n = 0, done_n = 0;
   int          stall_bad = 0, port2_bad = 0, ren1_n = 0;
   logic        prev_en = 1'b0, stall_prev = 1'b0;
   logic [63:0] stall_data = '0;

   always @(negedge clk) begin
      if (wen_ext) begin
         wen_addr.push_back(addr_ext);
         wen_data.push_back(wdata_ext);
      end
      if (ren_ext) ren1_n++;
      if (ren_ext_2) rd2_addr.push_back(addr_ext_2);
      if (cpu_enable) en_n++;
      if (cpu_enable && !prev_en) en_rise++;
      if (cpu_enable && (wen_ext || ren_ext || ren_ext_2)) en_bad++;
      prev_en = cpu_enable;
      if (busy) busy_n++;
      if (done) done_n++;
      if (wen_ext_2 || (wdata_ext_2 != 64'd0)) port2_bad++;
      if (m_valid && m_ready) mout.push_back(m_data);
      if (m_valid && !m_ready) begin
         if (stall_prev && (m_data != stall_data)) stall_bad++;
         stall_prev = 1'b1;
         stall_data = m_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [9:0] iw, input logic [31:0] rc,
                              input logic [9:0] db, input logic [10:0] dw);
      imem_words = iw;
      run_cycles = rc;
      dmem_base  = db;
      dmem_words = dw;
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   logic [31:0] ld_data [0:3] = '{32'h11, 32'h22, 32'h33, 32'h44};

   task automatic send_beats(input int n, input logic [3:0] gap_mask);
      for (int i = 0; i < n; i++) begin
         if (gap_mask[i]) begin
            s_valid = 1'b0;
            tick();
         end
         s_valid = 1'b1;
         s_data  = ld_data[i];
         begin
            int b = 0;
            @(negedge clk);
            while (!s_ready && b < 50) begin
               @(negedge clk);
               b++;
            end
         end
         check($sformatf("s_ready_beat%0d", i), s_ready, 1);
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      logic seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check(tag, seen, 1);
   endtask

   task automatic wait_mvalid(input int budget);
      logic seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (m_valid) seen = 1'b1;
      end
      check("mvalid_seen", seen, 1);
   endtask

   logic [63:0] exp_rd2  [0:3] = '{64'd8176, 64'd8184, 64'd0, 64'd8};
   logic [63:0] exp_mout [0:3] = '{64'hA5A5_0000_0000_03FE, 64'hA5A5_0000_0000_03FF,
                                   64'hA5A5_0000_0000_0000, 64'hA5A5_0000_0000_0001};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w0, r0, m0, e0, er0, eb0, d0, b0, sb0;
      for (int i = 0; i < 1024; i++) dmem[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
      arst_n = 1'b0; start = 1'b0; imem_words = '0; run_cycles = '0; dmem_base = '0;
      dmem_words = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cpu_enable", cpu_enable, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_imem_strobes", {wen_ext, ren_ext}, 0);
      check("rst_addr_ext", addr_ext, 0);
      check("rst_dmem_port", {wen_ext_2, ren_ext_2, addr_ext_2 != 64'd0}, 0);
      tick();
      arst_n = 1'b1;
      tick();

      // reset in the middle of LOAD after three beats
      pulse_start(10'd8, 32'd0, 10'd0, 11'd0);
      send_beats(3, 4'b0000);
      check("midload_busy", busy, 1);
      d0 = done_n;
      s_valid = 1'b1;
      arst_n  = 1'b0;
      #1;
      check("midload_rst_s_ready", s_ready, 0);
      check("midload_rst_busy", busy, 0);
      check("midload_rst_wen", wen_ext, 0);
      check("midload_rst_done", done, 0);
      s_valid = 1'b0;
      tick();
      tick();
      arst_n = 1'b1;
      repeat (3) tick();
      check("midload_no_done", done_n - d0, 0);
      check("midload_idle", busy, 0);

      // full sequence: load 4 with gaps, run 10, dump 4 from 1022 with stall
      w0 = wen_addr.size(); r0 = rd2_addr.size(); m0 = mout.size();
      e0 = en_n; er0 = en_rise; eb0 = en_bad; d0 = done_n; sb0 = stall_bad;
      m_ready = 1'b0;
      pulse_start(10'd4, 32'd10, 10'd1022, 11'd4);
      send_beats(4, 4'b0101);
      wait_mvalid(100);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      m_ready = 1'b1;
      wait_done(200, "full_done_seen");
      repeat (3) tick();
      m_ready = 1'b0;
      check("full_wen_count", wen_addr.size() - w0, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("full_wen_addr%0d", i), wen_addr[w0 + i], 64'(4 * i));
         check($sformatf("full_wen_data%0d", i), wen_data[w0 + i], 64'(ld_data[i]));
      end
      check("full_en_cycles", en_n - e0, 10);
      check("full_en_rises", en_rise - er0, 1);
      check("full_en_port_quiet", en_bad - eb0, 0);
      check("full_rd2_count", rd2_addr.size() - r0, 4);
      check("full_mout_count", mout.size() - m0, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("full_rd2_addr%0d", i), rd2_addr[r0 + i], exp_rd2[i]);
         check($sformatf("full_mdata%0d", i), mout[m0 + i], exp_mout[i]);
      end
      check("full_stall_stable", stall_bad - sb0, 0);
      check("full_done_count", done_n - d0, 1);
      check("full_busy_start_ignored", busy, 0);
`ifdef MEM_LOADER_VERIFY_EN
      check("full_verify_err_clean", verify_err, 0);
`endif

      // all lengths zero: done one cycle after start, no port activity
      w0 = wen_addr.size(); r0 = rd2_addr.size(); e0 = en_n; d0 = done_n; b0 = busy_n;
      imem_words = '0; run_cycles = '0; dmem_base = 10'd7; dmem_words = '0;
      start = 1'b1;
      @(negedge clk);
      check("zero_done_not_early", done, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check("zero_done_pulse", done, 1);
      @(negedge clk);
      check("zero_done_one_cycle", done, 0);
      check("zero_no_busy", busy_n - b0, 0);
      check("zero_no_ports", (wen_addr.size() - w0) + (rd2_addr.size() - r0) + (en_n - e0), 0);
      check("zero_done_count", done_n - d0, 1);
      tick();

      // load only: done after the last beat, run and dump skipped
      w0 = wen_addr.size(); r0 = rd2_addr.size(); e0 = en_n; d0 = done_n;
      pulse_start(10'd2, 32'd0, 10'd0, 11'd0);
      send_beats(2, 4'b0000);
      wait_done(50, "loadonly_done_seen");
      tick();
      check("loadonly_wen_count", wen_addr.size() - w0, 2);
      check("loadonly_imem1", imem[1], 32'h22);
      check("loadonly_skip", (rd2_addr.size() - r0) + (en_n - e0), 0);
      check("loadonly_done_count", done_n - d0, 1);

`ifdef MEM_LOADER_VERIFY_EN
      // corrupted readback of word 2 flags verify_err; dump still completes
      m0 = mout.size();
      corrupt_w2 = 1'b1;
      m_ready    = 1'b1;
      pulse_start(10'd4, 32'd0, 10'd5, 11'd2);
      send_beats(4, 4'b0000);
      wait_done(200, "verify_done_seen");
      tick();
      corrupt_w2 = 1'b0;
      m_ready    = 1'b0;
      check("verify_err_set", verify_err, 1);
      check("verify_dump_count", mout.size() - m0, 2);
      check("verify_dump_word0", mout[m0], 64'hA5A5_0000_0000_0005);
      pulse_start(10'd0, 32'd0, 10'd0, 11'd0);
      check("verify_err_cleared", verify_err, 0);
      tick();
`else
      check("no_imem_reads", ren1_n, 0);
`endif
      check("dmem_write_port_quiet", port2_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
